bomb_placement_ctrl: RTL and testbench
======================================

// Module: bomb_placement_ctrl
// PURPOSE
//  Sequences bomb placement for the 8x8 minesweeper board (64 cells, 6-bit cell index).
//  On start, clears the board map and draws cell indices from an internal LFSR.
//  Rejects duplicates and the protected safe cell until exactly num_bombs distinct cells are set.
//  Sits between the game FSM (start/safe_cell/num_bombs) and the board/display logic (bomb_map).
// PARAMETERS
//  LFSR_SEED  8'hA5  non-zero value loaded into the LFSR on reset (must be != 0)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   1-cycle request to generate a new board; honoured only in IDLE
//  num_bombs    in   6   bombs to place, 0..63; sampled in the start cycle
//  safe_cell    in   6   cell that must never hold a bomb; sampled in the start cycle
//  bomb_map     out  64  bit i = 1 -> cell i holds a bomb
//  bomb_count   out  6   bombs placed so far in the current run
//  busy         out  1   1 while in CLEAR or DRAW
//  done         out  1   1-cycle pulse when placement completes
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - bomb_map=0, bomb_count=0, busy=0, done=0, state=IDLE, lfsr=LFSR_SEED.
//    - Applies at any time, including mid-run; the run is abandoned and no done is issued.
//  - LFSR:
//    - 8-bit Fibonacci, taps 8,6,5,4: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//    - Advances every cycle in every state (free-running, so user timing adds entropy).
//    - Candidate cell = lfsr[5:0].
//  - FSM states: IDLE -> CLEAR -> DRAW -> DONE -> IDLE.
//    - IDLE: on start=1, latch target=num_bombs and safe=safe_cell, then go to CLEAR.
//      start in any other state is ignored.
//    - CLEAR (1 cycle): bomb_map<=0, bomb_count<=0.
//      If target==0, go to DONE; otherwise go to DRAW.
//    - DRAW (per cycle):
//      - If bomb_map[cand]==0 and cand!=safe: set bomb_map[cand] and increment bomb_count.
//      - Otherwise the draw is rejected; nothing changes and the next cycle retries.
//      - When the incremented count equals target, go to DONE.
//    - DONE (1 cycle): done=1, busy=0, then go to IDLE.
//  - bomb_map and bomb_count hold their values in IDLE/DONE until the next start or reset.
//  - Latency:
//    - start=1 at cycle T -> busy=1 from T+1.
//    - Placement #k is visible no earlier than T+2+k-1.
//    - done = 1 in the cycle after the last placement.
//  - Termination: the low 6 bits of the maximal-length 255-state sequence cover all 64 values.
//    Any free non-safe cell is therefore hit within 255 draws.
//    Bound: done <= 2 + 255*target cycles after start.
//  - target=63: all cells except safe end up set (the only possible map).
//  - bomb_count never exceeds target; bomb_map popcount always equals bomb_count.
// STRUCTURE
//  - Shared package minesweeper_pkg:
//    - BOARD_CELLS=64, CELL_W=6
//    - typedef enum logic[1:0] {IDLE, CLEAR, DRAW, DONE} placer_state_t
//  - Sub-module bomb_lfsr8 (clk, rst, seed parameter, q[7:0]):
//    free-running LFSR, reusable by other game blocks.
//  - Top: FSM, latched target/safe registers, map register, count register.
// TESTING
//  1. rst=1 mid-DRAW (after 5 placements)
//     -> map=0, count=0, busy=0 immediately; no done pulse.
//     A later start works normally.
//  2. start, num_bombs=10, safe_cell=27
//     -> one done pulse within 2552 cycles; popcount(map)=10, count=10, map[27]=0.
//  3. start, num_bombs=0
//     -> busy for 1 cycle (CLEAR), done 2 cycles after start, map=0.
//  4. start, num_bombs=63, safe_cell=0 -> map=64'hFFFF_FFFF_FFFF_FFFE, count=63.
//     Repeat with safe_cell=63 -> map=64'h7FFF_FFFF_FFFF_FFFF.
//  5. Second start pulse while busy with num_bombs=5
//     -> ignored; the run completes with the first target.
//     A start after done clears the map and regenerates.
//  6. Check every cycle: popcount(map)==count, map[safe]==0, done never asserted with busy.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board geometry, the placer FSM state type
// and the LFSR step function used by the free-running random source.
package minesweeper_pkg;

  localparam int BOARD_CELLS = 64;
  localparam int CELL_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } placer_state_t;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4 (maximal length, 255 states).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/bomb_placement_ctrl_if.sv
// Bus between the game FSM (master) and the bomb placer (slave).
//   start      : master -> slave, 1-cycle request for a new board
//   num_bombs  : master -> slave, bombs to place, sampled with start
//   safe_cell  : master -> slave, cell that never gets a bomb, sampled with start
//   bomb_map   : slave -> master, bit i set when cell i holds a bomb
//   bomb_count : slave -> master, bombs placed so far
//   busy       : slave -> master, high while a board is being generated
//   done       : slave -> master, 1-cycle completion pulse
// Handshake: start carries no ready. A start pulse is accepted only when the
// placer is idle (busy=0 and done=0); acceptance shows as busy=1 on the next
// cycle. A pulse while busy or during done is dropped.
interface bomb_placement_ctrl_if;
  import minesweeper_pkg::*;

  logic                   start;
  logic [CELL_W-1:0]      num_bombs;
  logic [CELL_W-1:0]      safe_cell;
  logic [BOARD_CELLS-1:0] bomb_map;
  logic [CELL_W-1:0]      bomb_count;
  logic                   busy;
  logic                   done;

  modport master (
    output start, num_bombs, safe_cell,
    input  bomb_map, bomb_count, busy, done
  );

  modport slave (
    input  start, num_bombs, safe_cell,
    output bomb_map, bomb_count, busy, done
  );

endinterface

// File: rtl/bomb_placement_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, reusable by any game block.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads SEED
//   q    : current LFSR value, advances every cycle
// SEED must be non-zero or the register locks up at zero.
module bomb_lfsr8
  import minesweeper_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = lfsr8_next(lfsr_q);
  assign q      = lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/bomb_placement_ctrl.sv
// Bomb placement sequencer for the 8x8 board.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (abandons any run, no done)
//   bus     : slave side of bomb_placement_ctrl_if (start/num_bombs/safe_cell
//             in; bomb_map/bomb_count/busy/done out)
//   state_o : current FSM state, for observation
// On an accepted start the map is cleared, then one LFSR candidate per cycle
// is tried until target distinct non-safe cells are set.
module bomb_placement_ctrl
  import minesweeper_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  bomb_placement_ctrl_if.slave bus,
  output placer_state_t       state_o
);

  placer_state_t          state_q, state_d;
  logic [CELL_W-1:0]      target_q, target_d;
  logic [CELL_W-1:0]      safe_q, safe_d;
  logic [BOARD_CELLS-1:0] map_q, map_d;
  logic [CELL_W-1:0]      count_q, count_d;

  logic [7:0]             lfsr;
  logic [CELL_W-1:0]      cand;
  logic [CELL_W-1:0]      count_inc;

  bomb_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign cand      = lfsr[CELL_W-1:0];
  // count_q stays below target (max 63) while drawing, so this never wraps.
  assign count_inc = count_q + 6'd1;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    safe_d   = safe_q;
    map_d    = map_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.num_bombs;
          safe_d   = bus.safe_cell;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        map_d   = '0;
        count_d = '0;
        state_d = (target_q == '0) ? DONE : DRAW;
      end
      DRAW: begin
        // Occupied or protected candidates are simply skipped; the LFSR
        // moves on and the next cycle tries again.
        if (!map_q[cand] && (cand != safe_q)) begin
          map_d[cand] = 1'b1;
          count_d     = count_inc;
          if (count_inc == target_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      safe_q   <= '0;
      map_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      safe_q   <= safe_d;
      map_q    <= map_d;
      count_q  <= count_d;
    end
  end

  assign bus.bomb_map   = map_q;
  assign bus.bomb_count = count_q;
  assign bus.busy       = (state_q == CLEAR) || (state_q == DRAW);
  assign bus.done       = (state_q == DONE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_bomb_placement_ctrl.sv
// Directed and randomized bench for bomb_placement_ctrl. The reference model
// replays the LFSR sequence and picks the first `target` distinct non-safe
// candidates to predict the exact map and the cycle of the done pulse.
module tb_bomb_placement_ctrl;
  import minesweeper_pkg::*;

  localparam logic [7:0] SEED = 8'hA5;

  logic          clk;
  logic          rst;
  placer_state_t state_o;
  int            checks;
  int            errors;

  // model LFSR register, tracking the DUT's free-running source
  logic [7:0]    m_lfsr;
  int            cur_safe;
  bit            safe_valid;

  bomb_placement_ctrl_if bus ();

  bomb_placement_ctrl #(.LFSR_SEED(SEED)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= step(m_lfsr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: draws start two LFSR steps after the start cycle; return the
  // resulting map and number of draw cycles needed.
  task automatic plan(input logic [7:0] l0, input int tgt, input int sf,
                      output logic [63:0] emap, output int n);
    logic [7:0] l;
    int         cnt;
    int         c;
    l    = step(step(l0));
    emap = '0;
    cnt  = 0;
    n    = 0;
    while (cnt < tgt && n < 20000) begin
      c = int'(l[5:0]);
      if (!emap[c] && c != sf) begin
        emap[c] = 1'b1;
        cnt++;
      end
      n++;
      l = step(l);
    end
  endtask

  // Every-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_popcount", 64'($countones(bus.bomb_map)), 64'(bus.bomb_count));
      check("inv_done_busy", 64'(bus.done & bus.busy), 64'd0);
      if (safe_valid) check("inv_safe", 64'(bus.bomb_map[cur_safe]), 64'd0);
    end
  end

  // driver: one full run, optional extra start pulse while busy
  task automatic run(input int tgt, input int sf, input bit glitch);
    logic [63:0] emap;
    int          n;
    logic [7:0]  l0;
    @(negedge clk);
    l0 = m_lfsr;
    plan(l0, tgt, sf, emap, n);
    check("plan_terminates", 64'(n < 20000), 64'd1);
    bus.start     = 1'b1;
    bus.num_bombs = 6'(tgt);
    bus.safe_cell = 6'(sf);
    for (int k = 1; k <= 2 + n; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 2) begin
        cur_safe   = sf;
        safe_valid = 1'b1;
      end
      if (glitch && k == 3) begin
        bus.start     = 1'b1;
        bus.num_bombs = 6'd5;
        bus.safe_cell = 6'd5;
      end
      check("busy_done", 64'({bus.busy, bus.done}),
            64'({(k <= 1 + n), (k == 2 + n)}));
    end
    bus.start = 1'b0;
    check("final_map",   bus.bomb_map, emap);
    check("final_count", 64'(bus.bomb_count), 64'(tgt));
    check("final_safe",  64'(bus.bomb_map[sf]), 64'd0);
    @(negedge clk);
    check("done_pulse_end", 64'({bus.busy, bus.done}), 64'd0);
    check("map_hold", bus.bomb_map, emap);
  endtask

  // stimulus
  initial begin
    logic [63:0] saved;
    bit          reached;
    int          tgt;
    int          sf;
    checks        = 0;
    errors        = 0;
    safe_valid    = 1'b0;
    cur_safe      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_bombs = '0;
    bus.safe_cell = '0;

    #1;
    check("rst_map",   bus.bomb_map, 64'd0);
    check("rst_count", 64'(bus.bomb_count), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_state", 64'(state_o), 64'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // nominal placement
    run(10, 27, 1'b0);
    // empty board
    run(0, $urandom_range(0, 63), 1'b0);
    // full boards, safe cell at each end
    run(63, 0, 1'b0);
    check("full_safe0", bus.bomb_map, 64'hFFFF_FFFF_FFFF_FFFE);
    run(63, 63, 1'b0);
    check("full_safe63", bus.bomb_map, 64'h7FFF_FFFF_FFFF_FFFF);
    // start while busy is dropped, later start regenerates
    run(10, 3, 1'b1);
    run(7, 40, 1'b0);

    // reset in the middle of DRAW
    safe_valid = 1'b0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_bombs = 6'd20;
    bus.safe_cell = 6'd27;
    @(negedge clk);
    bus.start = 1'b0;
    reached   = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      if (bus.bomb_count == 6'd5) reached = 1'b1;
    end
    check("midrun_reach5", 64'(reached), 64'd1);
    saved = bus.bomb_map;
    rst = 1'b1;
    #1;
    check("midrun_rst_map",   bus.bomb_map, 64'd0);
    check("midrun_rst_count", 64'(bus.bomb_count), 64'd0);
    check("midrun_rst_busy",  64'(bus.busy), 64'd0);
    check("midrun_rst_done",  64'(bus.done), 64'd0);
    check("midrun_had_bombs", 64'($countones(saved)), 64'd5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({bus.busy, bus.done}), 64'd0);
    end
    run(10, 27, 1'b0);

    // randomized runs with random idle gaps
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      tgt = $urandom_range(1, 40);
      sf  = $urandom_range(0, 63);
      run(tgt, sf, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
